// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port and a per-register
// pending scoreboard for decode interlocks. Optional macro REGFILE_BYPASS_EN adds write-through forwarding.
module regfile_scoreboard #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic [ADDR_W-1:0] ReadSelect1,
    input  logic [ADDR_W-1:0] ReadSelect2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    output logic              ReadValid1,
    output logic              ReadValid2,
    input  logic [ADDR_W-1:0] WriteSelect,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              WriteEnable,
    input  logic [ADDR_W-1:0] ReserveSelect,
    input  logic              ReserveEnable,
    output logic              ReserveAccept,
    output logic [ADDR_W:0]   PendingCount
);

    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = 1;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              wr_eff, rsv_set, cnt_inc, cnt_dec;

    function automatic logic is_zero(input logic [ADDR_W-1:0] sel);
        return (ZERO_REG != 0) && (sel == '0);
    endfunction

    // Read ports: register 0 is hardwired when ZERO_REG is set and never pending
    always_comb begin
        ReadData1  = is_zero(ReadSelect1) ? '0 : regs_q[ReadSelect1];
        ReadData2  = is_zero(ReadSelect2) ? '0 : regs_q[ReadSelect2];
        ReadValid1 = ~pend_q[ReadSelect1];
        ReadValid2 = ~pend_q[ReadSelect2];
`ifdef REGFILE_BYPASS_EN
        if (wr_eff && (WriteSelect == ReadSelect1)) begin
            ReadData1  = WriteData;
            ReadValid1 = 1'b1;
        end
        if (wr_eff && (WriteSelect == ReadSelect2)) begin
            ReadData2  = WriteData;
            ReadValid2 = 1'b1;
        end
`endif
    end

    // A reserve may take over a pending register in the very cycle its result lands
    assign ReserveAccept = ~Clear & ReserveEnable &
                           (~pend_q[ReserveSelect] |
                            (WriteEnable & (WriteSelect == ReserveSelect)));

    assign wr_eff  = WriteEnable & ~is_zero(WriteSelect);
    assign rsv_set = ReserveAccept & ~is_zero(ReserveSelect);
    assign cnt_inc = rsv_set & ~pend_q[ReserveSelect];
    assign cnt_dec = wr_eff & pend_q[WriteSelect] &
                     ~(rsv_set & (ReserveSelect == WriteSelect));

    always_comb begin
        pend_d = pend_q;
        if (wr_eff)
            pend_d[WriteSelect] = 1'b0;
        // Reserve is applied last so it wins over a same-register writeback
        if (rsv_set)
            pend_d[ReserveSelect] = 1'b1;
        cnt_d = cnt_q;
        case ({cnt_inc, cnt_dec})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            for (int i = 0; i < DEPTH; i++)
                regs_q[i] <= '0;
        end else if (wr_eff) begin
            regs_q[WriteSelect] <= WriteData;
        end
    end

    assign PendingCount = cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: driver queues hand-computed per-cycle
// expectations, an independent monitor compares them on the falling edge.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        clr;
    logic [3:0]  rs1, rs2, ws, rsv;
    logic [15:0] rd1, rd2, wd;
    logic        rv1, rv2, we, re, acc;
    logic [4:0]  cnt;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string       nm;
        logic [15:0] rd1;
        logic        rv1;
        logic [15:0] rd2;
        logic        rv2;
        logic        acc;
        logic [4:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    regfile_scoreboard #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) dut (
        .Clock(clk), .Clear(clr),
        .ReadSelect1(rs1), .ReadSelect2(rs2),
        .ReadData1(rd1), .ReadData2(rd2),
        .ReadValid1(rv1), .ReadValid2(rv2),
        .WriteSelect(ws), .WriteData(wd), .WriteEnable(we),
        .ReserveSelect(rsv), .ReserveEnable(re), .ReserveAccept(acc),
        .PendingCount(cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input string f, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", nm, f, act, expv);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the oldest queued expectation
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.nm, "rd1", rd1, e.rd1);
                check(e.nm, "rv1", {15'b0, rv1}, {15'b0, e.rv1});
                check(e.nm, "rd2", rd2, e.rd2);
                check(e.nm, "rv2", {15'b0, rv2}, {15'b0, e.rv2});
                check(e.nm, "acc", {15'b0, acc}, {15'b0, e.acc});
                check(e.nm, "cnt", {11'b0, cnt}, {11'b0, e.cnt});
            end
        end
    end

    task automatic cyc(input string nm, input bit c, input logic [3:0] s1, input logic [3:0] s2,
                       input bit w, input logic [3:0] wsel, input logic [15:0] wdat,
                       input bit r, input logic [3:0] rsel,
                       input logic [15:0] e_rd1, input bit e_rv1, input logic [15:0] e_rd2,
                       input bit e_rv2, input bit e_acc, input logic [4:0] e_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        clr = c; rs1 = s1; rs2 = s2; we = w; ws = wsel; wd = wdat; re = r; rsv = rsel;
        e.nm = nm; e.rd1 = e_rd1; e.rv1 = e_rv1; e.rd2 = e_rd2;
        e.rv2 = e_rv2; e.acc = e_acc; e.cnt = e_cnt;
        exp_q.push_back(e);
    endtask

    initial begin
        clr = 1'b1; rs1 = '0; rs2 = '0; we = 1'b0; ws = '0; wd = '0; re = 1'b0; rsv = '0;
        repeat (2) @(posedge clk);
        //        name            clr rs1 rs2 we ws wd        re rsv  rd1                     rv1  rd2       rv2 acc cnt
        cyc("reset_wr_r5",     0, 5, 0, 1, 5, 16'h1234, 0, 0, BYP ? 16'h1234 : 16'h0, 1, 16'h0, 1, 0, 0);
        cyc("read_r5",         0, 5, 5, 0, 0, 16'h0,    0, 0, 16'h1234, 1, 16'h1234, 1, 0, 0);
        cyc("rsv_r3",          0, 3, 5, 0, 0, 16'h0,    1, 3, 16'h0,    1, 16'h1234, 1, 1, 0);
        cyc("rsv_r3_again",    0, 3, 3, 0, 0, 16'h0,    1, 3, 16'h0,    0, 16'h0,    0, 0, 1);
        cyc("wb_r3",           0, 3, 5, 1, 3, 16'h00FF, 0, 0, BYP ? 16'h00FF : 16'h0, BYP, 16'h1234, 1, 0, 1);
        cyc("after_wb_r3",     0, 3, 3, 0, 0, 16'h0,    0, 0, 16'h00FF, 1, 16'h00FF, 1, 0, 0);
        cyc("rsv_r7",          0, 7, 3, 0, 0, 16'h0,    1, 7, 16'h0,    1, 16'h00FF, 1, 1, 0);
        cyc("wr_rsv_r7",       0, 7, 5, 1, 7, 16'hAAAA, 1, 7, BYP ? 16'hAAAA : 16'h0, BYP, 16'h1234, 1, 1, 1);
        cyc("r7_pending",      0, 7, 7, 1, 5, 16'h4321, 0, 0, 16'hAAAA, 0, 16'hAAAA, 0, 0, 1);
        cyc("zero_wr_rsv",     0, 0, 5, 1, 0, 16'hBEEF, 1, 0, 16'h0,    1, 16'h4321, 1, 1, 1);
        cyc("zero_after",      0, 0, 7, 0, 0, 16'h0,    0, 0, 16'h0,    1, 16'hAAAA, 0, 0, 1);
        cyc("wb_r7",           0, 7, 0, 1, 7, 16'h1111, 0, 0, BYP ? 16'h1111 : 16'hAAAA, BYP, 16'h0, 1, 0, 1);
        cyc("after_wb_r7",     0, 7, 0, 0, 0, 16'h0,    0, 0, 16'h1111, 1, 16'h0,    1, 0, 0);
        cyc("rsv_r1",          0, 1, 2, 0, 0, 16'h0,    1, 1, 16'h0,    1, 16'h0,    1, 1, 0);
        cyc("rsv_r2",          0, 1, 2, 0, 0, 16'h0,    1, 2, 16'h0,    0, 16'h0,    1, 1, 1);
        cyc("rsv_r4",          0, 2, 4, 0, 0, 16'h0,    1, 4, 16'h0,    0, 16'h0,    1, 1, 2);
        cyc("clear_with_wr",   1, 4, 5, 1, 2, 16'h7777, 1, 5, 16'h0,    0, 16'h4321, 1, 0, 3);
        cyc("post_clear",      0, 2, 5, 0, 0, 16'h0,    1, 6, 16'h0,    1, 16'h0,    1, 1, 0);
        cyc("late_wb_r2",      0, 4, 1, 1, 2, 16'h2222, 0, 0, 16'h0,    1, 16'h0,    1, 0, 1);
        cyc("after_late_wb",   0, 2, 6, 0, 0, 16'h0,    0, 0, 16'h2222, 1, 16'h0,    0, 0, 1);
        cyc("rsv_r9",          0, 9, 6, 0, 0, 16'h0,    1, 9, 16'h0,    1, 16'h0,    0, 1, 1);
        cyc("byp_r9",          0, 9, 9, 1, 9, 16'h5A5A, 0, 0, BYP ? 16'h5A5A : 16'h0, BYP, BYP ? 16'h5A5A : 16'h0, BYP, 0, 2);
        cyc("after_r9",        0, 9, 6, 0, 0, 16'h0,    0, 0, 16'h5A5A, 1, 16'h0,    0, 0, 1);
        @(posedge clk);
        #1;
        we = 1'b0; re = 1'b0; clr = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
